// File: rtl/dma_write_sched.sv
// rtl/dma_write_sched.sv - splits a DMA write job into boundary-safe engine chunks
module dma_write_sched #(
    parameter int MAX_CHUNK = 256,
    parameter int BOUNDARY  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_addr,
    input  logic [31:0] job_len,
    input  logic        abort,
    output logic        eng_start,
    output logic [31:0] eng_addr,
    output logic [15:0] eng_size,
    input  logic        eng_done,
    output logic        busy,
    output logic        job_done,
    output logic        aborted,
    output logic        err,
    output logic [15:0] chunk_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam logic [31:0] MAX_U   = 32'(MAX_CHUNK);
    localparam logic [31:0] BOUND_U = 32'(BOUNDARY);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cur_addr;
    logic [31:0] rem;
    logic        abort_pend;
    logic        err_q;
    logic        job_bad;
    logic [31:0] to_bound;
    logic [31:0] lim;
    logic [31:0] rem_after;

    assign job_bad = (job_len == 32'd0) || (job_addr[1:0] != 2'd0) || (job_len[1:0] != 2'd0);

    // eng_size doubles as the registered chunk length for the in-flight transfer
    always_comb begin
        to_bound  = BOUND_U - (cur_addr & (BOUND_U - 32'd1));
        lim       = (to_bound < MAX_U) ? to_bound : MAX_U;
        rem_after = rem - {16'd0, eng_size};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        busy      = 1'b1;
        eng_start = 1'b0;
        job_done  = 1'b0;
        aborted   = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid && !job_bad) begin
                    state_nxt = CALC;
                end
            end
            CALC:  state_nxt = abort ? FINISH : ISSUE;
            ISSUE: begin
                eng_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    state_nxt = (rem_after == 32'd0 || abort_pend || abort) ? FINISH : CALC;
                end
            end
            FINISH: begin
                job_done  = 1'b1;
                aborted   = abort_pend;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= 32'd0;
            rem        <= 32'd0;
            eng_addr   <= 32'd0;
            eng_size   <= 16'd0;
            chunk_cnt  <= 16'd0;
            abort_pend <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        chunk_cnt <= 16'd0;
                        if (job_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            cur_addr   <= job_addr;
                            rem        <= job_len;
                            abort_pend <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end else begin
                        eng_addr <= cur_addr;
                        eng_size <= (rem < lim) ? rem[15:0] : lim[15:0];
                    end
                end
                ISSUE: begin
                    if (abort) abort_pend <= 1'b1;
                end
                WAIT: begin
                    if (abort) abort_pend <= 1'b1;
                    if (eng_done) begin
                        cur_addr <= cur_addr + {16'd0, eng_size};
                        rem      <= rem_after;
                        if (chunk_cnt != 16'hFFFF) chunk_cnt <= chunk_cnt + 16'd1;
                    end
                end
                FINISH:  abort_pend <= 1'b0;
                default: ;
            endcase
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_dma_write_sched.sv
// tb/tb_dma_write_sched.sv - scoreboard bench for dma_write_sched
module tb_dma_write_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_addr = 32'd0;
    logic [31:0] job_len = 32'd0;
    logic        abort = 1'b0;
    logic        eng_start;
    logic [31:0] eng_addr;
    logic [15:0] eng_size;
    logic        eng_done = 1'b0;
    logic        busy;
    logic        job_done;
    logic        aborted;
    logic        err;
    logic [15:0] chunk_cnt;

    int tests = 0;
    int fails = 0;

    logic [47:0] chunk_q[$];
    logic [16:0] job_q[$];
    logic [31:0] err_q[$];

    dma_write_sched dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_addr(job_addr), .job_len(job_len), .abort(abort),
        .eng_start(eng_start), .eng_addr(eng_addr), .eng_size(eng_size),
        .eng_done(eng_done), .busy(busy), .job_done(job_done),
        .aborted(aborted), .err(err), .chunk_cnt(chunk_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // Monitor: every DUT output event must match the head of its scoreboard queue
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_start) begin
                if (chunk_q.size() == 0) flag("unexpected_eng_start");
                else check("eng_chunk", {eng_addr, eng_size}, chunk_q.pop_front());
            end
            if (job_done) begin
                if (job_q.size() == 0) flag("unexpected_job_done");
                else check("job_end", {31'd0, aborted, chunk_cnt}, {31'd0, job_q.pop_front()});
            end
            if (err) begin
                if (err_q.size() == 0) flag("unexpected_err");
                else begin
                    void'(err_q.pop_front());
                    check("err_idle", {46'd0, job_ready, busy}, 48'b10);
                end
            end
        end
    end

    // Write engine model: completes each chunk a few cycles after its start pulse
    always begin
        @(negedge clk);
        if (eng_start) begin
            repeat (3) @(posedge clk);
            #1 eng_done = 1'b1;
            @(posedge clk);
            #1 eng_done = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, {job_ready, busy, eng_start, job_done, aborted, err}, 48'b100000);
        check({name, "_regs"}, {eng_addr, eng_size}, 48'd0);
        check({name, "_cnt"}, {32'd0, chunk_cnt}, 48'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) flag("timeout_waiting_idle");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (!eng_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!eng_start) flag("timeout_waiting_eng_start");
    endtask

    // mode: 0 normal, 1 abort in first WAIT, 2 reset in first WAIT, 3 abort in CALC
    task automatic run_job(input logic [31:0] a, input logic [31:0] l, input int mode);
        @(posedge clk);
        #1 job_valid = 1'b1;
        job_addr = a;
        job_len = l;
        @(posedge clk);
        #1 job_valid = 1'b0;
        if (mode == 3) begin
            abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end else if (mode == 1 || mode == 2) begin
            wait_start();
            @(posedge clk);
            #1;
            if (mode == 1) abort = 1'b1;
            else rst = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            rst = 1'b0;
            if (mode == 2) begin
                @(negedge clk);
                check_reset_outputs("reset_in_wait");
                repeat (6) @(negedge clk);
                check("post_reset_eng_done_ignored", {31'd0, busy, chunk_cnt}, 48'd0);
            end
        end
        wait_idle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        chunk_q.push_back({32'h0, 16'h8});
        job_q.push_back({1'b0, 16'd1});
        run_job(32'h0, 32'h8, 0);

        chunk_q.push_back({32'h0FF0, 16'h10});
        chunk_q.push_back({32'h1000, 16'h30});
        job_q.push_back({1'b0, 16'd2});
        run_job(32'h0FF0, 32'h40, 0);

        for (int i = 0; i < 3; i++) chunk_q.push_back({32'(i * 256), 16'h100});
        job_q.push_back({1'b0, 16'd3});
        run_job(32'h0, 32'h300, 0);

        err_q.push_back(32'h2);
        run_job(32'h2, 32'h8, 0);
        err_q.push_back(32'h0);
        run_job(32'h0, 32'h0, 0);
        err_q.push_back(32'h0);
        run_job(32'h0, 32'h6, 0);
        check("ready_after_rejects", {46'd0, job_ready, busy}, 48'b10);

        chunk_q.push_back({32'h0F04, 16'h0FC});
        chunk_q.push_back({32'h1000, 16'h100});
        chunk_q.push_back({32'h1100, 16'h004});
        job_q.push_back({1'b0, 16'd3});
        run_job(32'h0F04, 32'h200, 0);

        chunk_q.push_back({32'h0, 16'h100});
        job_q.push_back({1'b1, 16'd1});
        run_job(32'h0, 32'h300, 1);

        job_q.push_back({1'b1, 16'd0});
        run_job(32'h40, 32'h10, 3);

        chunk_q.push_back({32'h0, 16'h100});
        run_job(32'h0, 32'h300, 2);

        chunk_q.push_back({32'h0, 16'h8});
        job_q.push_back({1'b0, 16'd1});
        run_job(32'h0, 32'h8, 0);

        check("chunk_q_drained", 48'(chunk_q.size()), 48'd0);
        check("job_q_drained", 48'(job_q.size()), 48'd0);
        check("err_q_drained", 48'(err_q.size()), 48'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_write_sched.md
DMA_WRITE_SCHED -- requirements
Module: dma_write_sched

Interface
REQ-001 SHALL have parameter MAX_CHUNK, default 256; the maximum bytes per engine transfer (power of two, multiple of 4, ≤ 32768).
REQ-002 SHALL have parameter BOUNDARY, default 4096; the address boundary no chunk may cross (power of two, ≥ MAX_CHUNK).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port job_valid, input, 1: a job request is present.
REQ-006 SHALL have port job_ready, output, 1: the scheduler accepts a job.
REQ-007 SHALL have port job_addr, input, 32: job start byte address.
REQ-008 SHALL have port job_len, input, 32: job length in bytes.
REQ-009 SHALL have port abort, input, 1: stop the job after the in-flight chunk.
REQ-010 SHALL have port eng_start, output, 1: one-cycle start pulse to the write engine.
REQ-011 SHALL have port eng_addr, output, 32: chunk start address.
REQ-012 SHALL have port eng_size, output, 16: chunk length in bytes.
REQ-013 SHALL have port eng_done, input, 1: engine chunk-complete pulse.
REQ-014 SHALL have port busy, output, 1: a job is in progress.
REQ-015 SHALL have port job_done, output, 1: one-cycle pulse marking job end.
REQ-016 SHALL have port aborted, output, 1: qualifies job_done; the job ended by abort.
REQ-017 SHALL have port err, output, 1: one-cycle pulse marking a rejected job.
REQ-018 SHALL have port chunk_cnt, output, 16: chunks completed in the current or last job.

Function
REQ-019 SHALL implement states IDLE, CALC, ISSUE, WAIT, FINISH.
REQ-020 In IDLE, job_ready SHALL be 1; in all other states job_ready SHALL be 0.
REQ-021 A job SHALL be accepted on the cycle job_valid && job_ready; acceptance latches job_addr and job_len.
REQ-022 On acceptance, chunk_cnt SHALL be cleared to 0.
REQ-023 A job SHALL be rejected if job_len==0, job_addr[1:0]!=0 or job_len[1:0]!=0.
REQ-024 On rejection, err SHALL pulse 1 on the next cycle, the state SHALL remain IDLE, and eng_start SHALL not assert.
REQ-025 A valid job SHALL move IDLE->CALC.
REQ-026 CALC SHALL last 1 cycle and register chunk = min(rem, MAX_CHUNK, BOUNDARY - (cur_addr mod BOUNDARY)), using 32-bit unsigned arithmetic.
REQ-027 CALC->ISSUE.
REQ-028 ISSUE SHALL last 1 cycle with eng_start=1 and eng_addr/eng_size valid.
REQ-029 eng_addr/eng_size SHALL hold stable from ISSUE until eng_done.
REQ-030 ISSUE->WAIT.
REQ-031 WAIT SHALL hold until eng_done=1; then cur_addr += chunk, rem -= chunk, chunk_cnt += 1, all in the same edge.
REQ-032 On eng_done, if rem becomes 0 or an abort is pending, the state SHALL go to FINISH; otherwise to CALC.
REQ-033 FINISH SHALL last 1 cycle with job_done=1 and aborted = the abort-pending flag, then go to IDLE and clear the flag.
REQ-034 abort SHALL be sampled in CALC, ISSUE and WAIT.
REQ-035 An abort sampled in CALC SHALL go directly to FINISH with no eng_start and aborted=1.
REQ-036 An abort sampled in ISSUE or WAIT SHALL set the pending flag; the in-flight chunk always completes.
REQ-037 abort in IDLE or FINISH SHALL be ignored.
REQ-038 eng_done outside WAIT SHALL be ignored.
REQ-039 An eng_done coincident with abort in WAIT SHALL end the job via FINISH with aborted=1.
REQ-040 busy SHALL be 1 in CALC, ISSUE, WAIT and FINISH.
REQ-041 chunk_cnt SHALL saturate at 0xFFFF.
REQ-042 A new job SHALL be acceptable in the cycle after FINISH.

Reset
REQ-043 With rst=1 at a clock edge, the state SHALL become IDLE.
REQ-044 Reset SHALL set job_ready=1 and busy, eng_start, job_done, aborted and err to 0.
REQ-045 Reset SHALL set eng_addr, eng_size and chunk_cnt to 0, and clear the pending abort.
REQ-046 Reset mid-job SHALL discard the job with no job_done; a subsequent eng_done SHALL be ignored.

Verification
REQ-047 Job addr=0x0, len=8, eng_done 3 cycles after start -> one eng_start with addr 0x0, size 8; job_done at FINISH; chunk_cnt=1; aborted=0.
REQ-048 Job addr=0x0FF0, len=0x40 -> chunk (0x0FF0, 0x10) then (0x1000, 0x30); chunk_cnt=2.
REQ-049 Job addr=0x0, len=0x300 -> three chunks of 0x100 at 0x0, 0x100, 0x200; exactly one job_done.
REQ-050 Job addr=0x2, len=8; then addr=0, len=0 -> an err pulse for each; no eng_start; job_ready stays 1.
REQ-051 Job len=0x300 with abort asserted during the first WAIT -> that chunk completes; job_done with aborted=1; chunk_cnt=1; no second eng_start.
REQ-052 rst asserted in WAIT -> all outputs at reset values next cycle; a later eng_done is ignored; a new job (0x0, 8) completes normally.
